// File: rtl/muon_core_n.sv
// -----------------------------------------------------------------------------
// muon_core_n
// Front-end core for the muon-lifetime counter. It debounces N_CH raw
// detector/button inputs and counts the rising edge of each debounced channel.
// It also counts coincidences over a selectable set of channels. A single-shot
// TDC measures the number of clock cycles between a start-channel edge and a
// stop-channel edge.
//
// Build option:
//   MUON_COUNT_SAT_EN  defined   -> hit, coincidence and timeout counters
//                                   saturate at all-ones
//                      undefined -> those counters wrap to zero
//   The TDC interval timer always stops at its timeout and is not affected
//   by this option.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active high
//   ch_in         raw asynchronous channel inputs
//   coinc_mask    channels that must all be high for a coincidence
//   clear         synchronous clear of all counters and the TDC state
//   level         debounced channel levels
//   counts        hit counters; channel i is at [i*CNT_W +: CNT_W]
//   coinc_count   coincidence counter
//   tdc_value     last measured interval, in cycles
//   tdc_valid     one-cycle pulse when tdc_value updates
//   tdc_busy      high while a measurement is running
//   tdc_timeouts  number of measurements that ended without a stop
//
// TDC states:
//   state   | meaning
//   ST_IDLE | waiting for a start-channel rising edge
//   ST_RUN  | timer running, waiting for a stop edge or a timeout
// -----------------------------------------------------------------------------
module muon_core_n #(
    parameter int N_CH            = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16,
    parameter int TDC_W           = 16,
    parameter int TDC_START_CH    = 0,
    parameter int TDC_STOP_CH     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       ch_in,
    input  logic [N_CH-1:0]       coinc_mask,
    input  logic                  clear,
    output logic [N_CH-1:0]       level,
    output logic [N_CH*CNT_W-1:0] counts,
    output logic [CNT_W-1:0]      coinc_count,
    output logic [TDC_W-1:0]      tdc_value,
    output logic                  tdc_valid,
    output logic                  tdc_busy,
    output logic [TDC_W-1:0]      tdc_timeouts
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_RUN} tdc_state_t;

    logic [N_CH-1:0]  sync_q1;
    logic [N_CH-1:0]  sync_q2;
    logic [DB_W-1:0]  db_cnt [N_CH];
    logic [N_CH-1:0]  level_prev;
    logic [N_CH-1:0]  rise;
    logic [CNT_W-1:0] hit_cnt [N_CH];
    logic             all_hit;
    logic             all_hit_prev;
    tdc_state_t       tdc_state;
    logic [TDC_W-1:0] tdc_timer;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef MUON_COUNT_SAT_EN
        cnt_inc = (&v) ? v : v + CNT_W'(1);
`else
        cnt_inc = v + CNT_W'(1);
`endif
    endfunction

    function automatic logic [TDC_W-1:0] tmo_inc(input logic [TDC_W-1:0] v);
`ifdef MUON_COUNT_SAT_EN
        tmo_inc = (&v) ? v : v + TDC_W'(1);
`else
        tmo_inc = v + TDC_W'(1);
`endif
    endfunction

    // Synchroniser and debounce. A new level must persist for DEBOUNCE_CYCLES
    // consecutive synchronised samples; any return to the current level
    // restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1    <= '0;
            sync_q2    <= '0;
            level      <= '0;
            level_prev <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_q1    <= ch_in;
            sync_q2    <= sync_q1;
            level_prev <= level;
            for (int i = 0; i < N_CH; i++) begin
                if (sync_q2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync_q2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise = level & ~level_prev;

    // An empty mask must never produce a coincidence, so the reduction is
    // qualified by the mask being non-zero.
    assign all_hit = (|coinc_mask) & (&(level | ~coinc_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_hit_prev <= 1'b0;
            coinc_count  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hit_cnt[i] <= '0;
            end
        end else begin
            // Edge history keeps tracking through a clear so that a level
            // that was already high does not count once the clear is released.
            all_hit_prev <= all_hit;
            if (clear) begin
                coinc_count <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    hit_cnt[i] <= '0;
                end
            end else begin
                if (all_hit && !all_hit_prev) begin
                    coinc_count <= cnt_inc(coinc_count);
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (rise[i]) begin
                        hit_cnt[i] <= cnt_inc(hit_cnt[i]);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_counts
        assign counts[g*CNT_W +: CNT_W] = hit_cnt[g];
    end

    // TDC. The timer starts at 1 in the cycle after the start edge, so the
    // value captured on the stop edge equals the distance between the two
    // rise pulses. A stop arriving as the timer reaches all-ones is still a
    // valid measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdc_state    <= ST_IDLE;
            tdc_timer    <= '0;
            tdc_value    <= '0;
            tdc_valid    <= 1'b0;
            tdc_busy     <= 1'b0;
            tdc_timeouts <= '0;
        end else if (clear) begin
            tdc_state    <= ST_IDLE;
            tdc_timer    <= '0;
            tdc_value    <= '0;
            tdc_valid    <= 1'b0;
            tdc_busy     <= 1'b0;
            tdc_timeouts <= '0;
        end else begin
            tdc_valid <= 1'b0;
            case (tdc_state)
                ST_IDLE: begin
                    if (rise[TDC_START_CH]) begin
                        tdc_timer <= TDC_W'(1);
                        tdc_state <= ST_RUN;
                        tdc_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rise[TDC_STOP_CH]) begin
                        tdc_value <= tdc_timer;
                        tdc_valid <= 1'b1;
                        tdc_state <= ST_IDLE;
                        tdc_busy  <= 1'b0;
                    end else if (&tdc_timer) begin
                        tdc_timeouts <= tmo_inc(tdc_timeouts);
                        tdc_state    <= ST_IDLE;
                        tdc_busy     <= 1'b0;
                    end else begin
                        tdc_timer <= tdc_timer + TDC_W'(1);
                    end
                end
                default: begin
                    tdc_state <= ST_IDLE;
                    tdc_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muon_core_n.sv
module tb_muon_core_n;

    localparam int N_CH  = 3;
    localparam int DB    = 4;
    localparam int CNT_W = 4;
    localparam int TDC_W = 8;

    logic                  clk;
    logic                  rst;
    logic [N_CH-1:0]       ch_in;
    logic [N_CH-1:0]       coinc_mask;
    logic                  clear;
    logic [N_CH-1:0]       level;
    logic [N_CH*CNT_W-1:0] counts;
    logic [CNT_W-1:0]      coinc_count;
    logic [TDC_W-1:0]      tdc_value;
    logic                  tdc_valid;
    logic                  tdc_busy;
    logic [TDC_W-1:0]      tdc_timeouts;

    int checks   = 0;
    int failures = 0;

    muon_core_n #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W), .TDC_W(TDC_W),
        .TDC_START_CH(0), .TDC_STOP_CH(1)
    ) dut (
        .clk(clk), .rst(rst), .ch_in(ch_in), .coinc_mask(coinc_mask),
        .clear(clear), .level(level), .counts(counts),
        .coinc_count(coinc_count), .tdc_value(tdc_value),
        .tdc_valid(tdc_valid), .tdc_busy(tdc_busy),
        .tdc_timeouts(tdc_timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        return 32'(counts[i*CNT_W +: CNT_W]);
    endfunction

    task automatic pulse(input int ch, input int hi, input int lo);
        ch_in[ch] = 1'b1;
        tick(hi);
        ch_in[ch] = 1'b0;
        tick(lo);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"},    32'(level), 0);
        check({tag, "_counts"},   32'(counts), 0);
        check({tag, "_coinc"},    32'(coinc_count), 0);
        check({tag, "_tdc_val"},  32'(tdc_value), 0);
        check({tag, "_valid"},    32'(tdc_valid), 0);
        check({tag, "_busy"},     32'(tdc_busy), 0);
        check({tag, "_timeouts"}, 32'(tdc_timeouts), 0);
    endtask

    initial begin
        logic             seen;
        int               vcount;
        logic [TDC_W-1:0] vval;
        int               exp17;

        rst        = 1'b1;
        ch_in      = '0;
        coinc_mask = '0;
        clear      = 1'b0;
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(2);

        // Debounce latency and clean pulses on ch2
        ch_in[2] = 1'b1;
        tick(5);
        check("lat_level_edge4", 32'(level[2]), 0);
        tick(1);
        check("lat_level_edge5", 32'(level[2]), 1);
        check("lat_count_edge5", cnt_of(2), 0);
        tick(1);
        check("lat_count_edge6", cnt_of(2), 1);
        tick(13);
        ch_in[2] = 1'b0;
        tick(20);
        for (int p = 0; p < 9; p++) pulse(2, 20, 20);
        tick(10);
        check("pulses_ch2", cnt_of(2), 10);
        check("pulses_ch0", cnt_of(0), 0);
        check("pulses_ch1", cnt_of(1), 0);

        // 3-cycle glitch on ch0 must be rejected
        seen = 1'b0;
        ch_in[0] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) ch_in[0] = 1'b0;
            tick(1);
            seen = seen | level[0] | tdc_busy;
        end
        check("glitch_seen", 32'(seen), 0);
        check("glitch_count", cnt_of(0), 0);

        // Coincidence over ch0/ch1; these also drive 5-cycle TDC measurements
        coinc_mask = 3'b011;
        for (int p = 0; p < 5; p++) begin
            ch_in[0] = 1'b1; tick(5);
            ch_in[1] = 1'b1; tick(20);
            ch_in[0] = 1'b0; tick(5);
            ch_in[1] = 1'b0; tick(20);
        end
        check("coinc_mask011", 32'(coinc_count), 5);
        check("coinc_ch0_hits", cnt_of(0), 5);
        check("coinc_ch1_hits", cnt_of(1), 5);
        check("coinc_tdc5", 32'(tdc_value), 5);
        check("coinc_busy", 32'(tdc_busy), 0);

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_coinc", 32'(coinc_count), 0);
        check("clear_counts", 32'(counts), 0);
        check("clear_tdc_val", 32'(tdc_value), 0);

        coinc_mask = 3'b000;
        for (int p = 0; p < 5; p++) begin
            ch_in[0] = 1'b1; tick(5);
            ch_in[1] = 1'b1; tick(20);
            ch_in[0] = 1'b0; tick(5);
            ch_in[1] = 1'b0; tick(20);
        end
        check("coinc_mask000", 32'(coinc_count), 0);
        check("mask000_ch0_hits", cnt_of(0), 5);

        // Mask change that makes all_hit rise counts once
        ch_in[2] = 1'b1;
        tick(10);
        check("maskchg_level2", 32'(level[2]), 1);
        coinc_mask = 3'b100;
        check("maskchg_before", 32'(coinc_count), 0);
        tick(1);
        check("maskchg_after", 32'(coinc_count), 1);
        coinc_mask = 3'b000;
        ch_in[2] = 1'b0;
        tick(10);

        // 137-cycle measurement with an ignored second start
        ch_in[0] = 1'b1; tick(10);
        ch_in[0] = 1'b0; tick(40);
        ch_in[0] = 1'b1; tick(10);
        ch_in[0] = 1'b0; tick(10);
        check("tdc137_busy", 32'(tdc_busy), 1);
        tick(67);
        ch_in[1] = 1'b1;
        vcount = 0;
        vval   = '0;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) ch_in[1] = 1'b0;
            tick(1);
            if (tdc_valid) begin
                vcount++;
                vval = tdc_value;
            end
        end
        check("tdc137_valid_pulses", 32'(vcount), 1);
        check("tdc137_value_at_valid", 32'(vval), 137);
        check("tdc137_value", 32'(tdc_value), 137);
        check("tdc137_busy_after", 32'(tdc_busy), 0);

        // Stop lands exactly when the timer is all-ones: stop wins
        ch_in[0] = 1'b1; tick(10);
        ch_in[0] = 1'b0; tick(245);
        ch_in[1] = 1'b1; tick(10);
        ch_in[1] = 1'b0; tick(20);
        check("tdc255_value", 32'(tdc_value), 255);
        check("tdc255_timeouts", 32'(tdc_timeouts), 0);

        // Start with no stop: timeout after the timer reaches 255
        ch_in[0] = 1'b1; tick(10);
        ch_in[0] = 1'b0; tick(251);
        check("tmo_busy_before", 32'(tdc_busy), 1);
        check("tmo_count_before", 32'(tdc_timeouts), 0);
        tick(1);
        check("tmo_busy_after", 32'(tdc_busy), 0);
        check("tmo_count_after", 32'(tdc_timeouts), 1);
        check("tmo_value_kept", 32'(tdc_value), 255);
        check("tmo_no_valid", 32'(tdc_valid), 0);

        // 17 pulses on a 4-bit counter
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear2_timeouts", 32'(tdc_timeouts), 0);
        for (int p = 0; p < 17; p++) pulse(2, 10, 10);
        tick(10);
`ifdef MUON_COUNT_SAT_EN
        exp17 = 15;
`else
        exp17 = 1;
`endif
        check("count17_ch2", cnt_of(2), 32'(exp17));

        // clear in the middle of a measurement
        ch_in[0] = 1'b1; tick(10);
        ch_in[0] = 1'b0; tick(20);
        check("midclr_busy_before", 32'(tdc_busy), 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("midclr_busy", 32'(tdc_busy), 0);
        check("midclr_valid", 32'(tdc_valid), 0);
        check("midclr_counts", 32'(counts), 0);
        check("midclr_coinc", 32'(coinc_count), 0);
        check("midclr_tdc_val", 32'(tdc_value), 0);
        check("midclr_timeouts", 32'(tdc_timeouts), 0);
        ch_in[1] = 1'b1;
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) ch_in[1] = 1'b0;
            tick(1);
            if (tdc_valid) vcount++;
        end
        check("midclr_stop_ignored", 32'(vcount), 0);
        check("midclr_tdc_val_after", 32'(tdc_value), 0);

        // Asynchronous reset in the middle of a measurement
        ch_in[2] = 1'b1;
        ch_in[0] = 1'b1; tick(10);
        ch_in[0] = 1'b0; tick(10);
        check("rst_busy_before", 32'(tdc_busy), 1);
        check("rst_level2_before", 32'(level[2]), 1);
        rst = 1'b1;
        #1;
        check_reset_values("rst_pulse");
        ch_in = '0;
        tick(2);
        rst = 1'b0;
        tick(20);
        check("post_rst_busy", 32'(tdc_busy), 0);
        check("post_rst_tdc_val", 32'(tdc_value), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
